// File: rtl/spi_sample_averager.sv
// rtl/spi_sample_averager.sv - fixed-rate SPI sample reader producing a 2^AVG_LOG2 mean
//
// Purpose:
//   Issues a read request to the 16-bit SPI read master every SAMPLE_PERIOD
//   clocks. It accumulates 2^AVG_LOG2 unsigned samples and offers the
//   truncated mean on a valid/ready port. The SPI master runs on its own
//   divided SCLK, so d_ready is synchronized into clk before use.
//
// Ports:
//   clk          system clock
//   rst_l        asynchronous active-low reset
//   enable       run periodic sampling while high
//   rd           read request to the SPI master
//   d_ready      SPI master data-ready (asynchronous to clk)
//   d            SPI master data, stable while d_ready is high
//   avg_valid    average available
//   avg_ready    downstream accepts the average
//   avg_data     averaged sample
//   timeout_err  sticky flag: a request was aborted for lack of d_ready
//   clear_err    synchronous clear of timeout_err (a simultaneous set wins)

module spi_sample_averager #(
  parameter int DATA_W         = 16,
  parameter int AVG_LOG2       = 3,
  parameter int SAMPLE_PERIOD  = 50000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              enable,
  output logic              rd,
  input  logic              d_ready,
  input  logic [DATA_W-1:0] d,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic [DATA_W-1:0] avg_data,
  output logic              timeout_err,
  input  logic              clear_err
);

  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(1 << AVG_LOG2);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    REQ,
    CAPTURE,
    ACK,
    OUT
  } state_t;

  state_t state;
  state_t state_next;

  // d_ready synchronizer
  logic dr_meta;
  logic dr_s;

  logic [TICK_W-1:0] tick;
  logic [TMO_W-1:0]  tmo;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;

  // Datapath strobes decoded by the next-state logic
  logic tick_clr;
  logic tick_inc;
  logic tmo_clr;
  logic tmo_inc;
  logic acc_clr;
  logic acc_add;
  logic avg_load;
  logic avg_drop;
  logic err_set;
  logic rd_next;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      dr_meta <= 1'b0;
      dr_s    <= 1'b0;
    end else begin
      dr_meta <= d_ready;
      dr_s    <= dr_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tick_clr   = 1'b0;
    tick_inc   = 1'b0;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    acc_clr    = 1'b0;
    acc_add    = 1'b0;
    avg_load   = 1'b0;
    avg_drop   = 1'b0;
    err_set    = 1'b0;

    case (state)
      IDLE: begin
        if (enable) begin
          tick_clr   = 1'b1;
          state_next = WAIT_TICK;
        end
      end

      WAIT_TICK: begin
        if (!enable) begin
          acc_clr    = 1'b1;
          state_next = IDLE;
        end else if (tick == TICK_LAST) begin
          // A still-high dr_s is stale, left over from an aborted request.
          // Hold at expiry until it clears so it is never taken as new data.
          if (!dr_s) begin
            tmo_clr    = 1'b1;
            state_next = REQ;
          end
        end else begin
          tick_inc = 1'b1;
        end
      end

      REQ: begin
        if (dr_s) begin
          state_next = CAPTURE;
        end else if (tmo == TMO_LAST) begin
          err_set    = 1'b1;
          acc_clr    = 1'b1;
          tick_clr   = 1'b1;
          state_next = WAIT_TICK;
        end else begin
          tmo_inc = 1'b1;
        end
      end

      CAPTURE: begin
        // d has been stable for at least the two synchronizer cycles
        acc_add    = 1'b1;
        state_next = ACK;
      end

      ACK: begin
        if (!dr_s) begin
          if (!enable) begin
            // A stop request during a transaction drops the partial mean
            acc_clr    = 1'b1;
            state_next = IDLE;
          end else if (cnt == CNT_FULL) begin
            avg_load   = 1'b1;
            acc_clr    = 1'b1;
            state_next = OUT;
          end else begin
            tick_clr   = 1'b1;
            state_next = WAIT_TICK;
          end
        end
      end

      OUT: begin
        // Sampling stalls here until the pending average is taken
        if (avg_ready) begin
          avg_drop   = 1'b1;
          tick_clr   = 1'b1;
          state_next = enable ? WAIT_TICK : IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // rd is registered from the next state, so it is glitch-free and is
  // cleared at once by the asynchronous reset.
  assign rd_next = (state_next == REQ) || (state_next == CAPTURE);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd          <= 1'b0;
      tick        <= '0;
      tmo         <= '0;
      acc         <= '0;
      cnt         <= '0;
      avg_valid   <= 1'b0;
      avg_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      rd <= rd_next;

      if (tick_clr) begin
        tick <= '0;
      end else if (tick_inc) begin
        tick <= tick + 1'b1;
      end

      if (tmo_clr) begin
        tmo <= '0;
      end else if (tmo_inc) begin
        tmo <= tmo + 1'b1;
      end

      if (acc_clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (acc_add) begin
        acc <= acc + ACC_W'(d);
        cnt <= cnt + 1'b1;
      end

      if (avg_load) begin
        avg_data  <= DATA_W'(acc >> AVG_LOG2);
        avg_valid <= 1'b1;
      end else if (avg_drop) begin
        avg_valid <= 1'b0;
      end

      if (err_set) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_sample_averager.sv
// tb/tb_spi_sample_averager.sv - self-checking bench for spi_sample_averager

module tb_spi_sample_averager;

  localparam int DW = 16;
  localparam int AL = 2;
  localparam int SP = 8;
  localparam int TO = 64;
  localparam int NS = 1 << AL;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          enable = 1'b0;
  logic          rd;
  logic          d_ready = 1'b0;
  logic [DW-1:0] d = '0;
  logic          avg_valid;
  logic          avg_ready = 1'b1;
  logic [DW-1:0] avg_data;
  logic          timeout_err;
  logic          clear_err = 1'b0;

  always #5 clk = ~clk;

  spi_sample_averager #(
    .DATA_W(DW),
    .AVG_LOG2(AL),
    .SAMPLE_PERIOD(SP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .enable(enable),
    .rd(rd),
    .d_ready(d_ready),
    .d(d),
    .avg_valid(avg_valid),
    .avg_ready(avg_ready),
    .avg_data(avg_data),
    .timeout_err(timeout_err),
    .clear_err(clear_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model: kind 0 answers, 1 never answers, 2 never answers but
  // raises a late d_ready shortly after the abort.
  typedef struct {
    int            kind;
    logic [DW-1:0] data;
  } resp_t;

  resp_t resp_q[$];
  int    rd_rises = 0;
  int    serves = 0;
  int    min_gap = 1000000;
  int    last_fall = -1000;
  int    last_silent_len = 0;
  int    stale_rd_bad = 0;
  int    stale_done = 0;

  initial begin : bfm
    resp_t r;
    logic  rd_prev;
    int    n;
    rd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rd && !rd_prev) begin
        rd_rises++;
        if (cyc - last_fall < min_gap) min_gap = cyc - last_fall;
        if (resp_q.size() > 0) begin
          r = resp_q.pop_front();
        end else begin
          r.kind = 0;
          r.data = 16'($urandom);
        end
        if (r.kind == 0) begin
          repeat ($urandom_range(1, 5)) @(negedge clk);
          d = r.data;
          d_ready = 1'b1;
          n = 0;
          while (rd && n < 200) begin @(negedge clk); n++; end
          repeat ($urandom_range(0, 3)) @(negedge clk);
          d_ready = 1'b0;
          d = 16'($urandom);
          last_fall = cyc;
          serves++;
        end else begin
          n = 0;
          while (rd && n < 200) begin @(negedge clk); n++; end
          last_silent_len = n;
          if (r.kind == 2) begin
            repeat (3) @(negedge clk);
            d = 16'hBEEF;
            d_ready = 1'b1;
            repeat (15) begin
              @(negedge clk);
              if (rd) stale_rd_bad++;
            end
            d_ready = 1'b0;
            d = 16'($urandom);
            last_fall = cyc;
            stale_done++;
          end
        end
      end
      rd_prev = rd;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // Reference: the mean of a group is the plain integer mean of its samples
  function automatic logic [DW-1:0] ref_mean(input logic [DW-1:0] s[$]);
    longint sum;
    sum = 0;
    foreach (s[i]) sum += longint'(s[i]);
    return DW'(sum / longint'(s.size()));
  endfunction

  task automatic push(input int kind, input logic [DW-1:0] v);
    resp_t r;
    r.kind = kind;
    r.data = v;
    resp_q.push_back(r);
  endtask

  task automatic get_avg(output logic [DW-1:0] val, output bit ok);
    ok = 1'b0;
    val = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (avg_valid) begin
        val = avg_data;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic stop_sampling();
    int quiet;
    quiet = 0;
    enable = 1'b0;
    for (int i = 0; i < 3000 && quiet < 30; i++) begin
      @(negedge clk);
      if (!rd && !d_ready && !avg_valid) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 30) begin
      errors++;
      $display("FAIL stop_quiet: got %0d quiet cycles want 30", quiet);
    end
    resp_q.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", rd); end
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL reset_avg_valid: got %b want 0", avg_valid); end
    checks++; if (avg_data !== '0) begin errors++; $display("FAIL reset_avg_data: got %h want 0000", avg_data); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    rst_l = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [DW-1:0] s[$];
    logic [DW-1:0] v;
    bit            ok;
    int            base;
    s = '{16'h0010, 16'h0020, 16'h0030, 16'h0041};
    foreach (s[i]) push(0, s[i]);
    base = rd_rises;
    min_gap = 1000000;
    enable = 1'b1;
    get_avg(v, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_valid: got no avg_valid want one"); end
    checks++; if (v !== ref_mean(s)) begin errors++; $display("FAIL basic_avg: got %h want %h", v, ref_mean(s)); end
    checks++; if (rd_rises - base != NS) begin errors++; $display("FAIL basic_rd_count: got %0d want %0d", rd_rises - base, NS); end
    stop_sampling();
    checks++; if (min_gap < SP) begin errors++; $display("FAIL basic_rd_gap: got %0d want >= %0d", min_gap, SP); end
  endtask

  task automatic test_full_scale();
    logic [DW-1:0] s1[$];
    logic [DW-1:0] s2[$];
    logic [DW-1:0] v;
    bit            ok;
    s1 = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    s2 = '{16'h0001, 16'h0001, 16'h0001, 16'h0000};
    foreach (s1[i]) push(0, s1[i]);
    foreach (s2[i]) push(0, s2[i]);
    enable = 1'b1;
    get_avg(v, ok);
    checks++; if (!ok || v !== ref_mean(s1)) begin errors++; $display("FAIL full_scale: got %h ok=%0d want %h", v, ok, ref_mean(s1)); end
    get_avg(v, ok);
    checks++; if (!ok || v !== ref_mean(s2)) begin errors++; $display("FAIL truncate: got %h ok=%0d want %h", v, ok, ref_mean(s2)); end
    stop_sampling();
  endtask

  task automatic test_random();
    logic [DW-1:0] s[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] v;
    bit            ok;
    for (int g = 0; g < 3; g++) begin
      s.delete();
      for (int k = 0; k < NS; k++) begin
        v = 16'($urandom);
        s.push_back(v);
        push(0, v);
      end
      exp_q.push_back(ref_mean(s));
    end
    enable = 1'b1;
    for (int g = 0; g < 3; g++) begin
      get_avg(v, ok);
      checks++;
      if (!ok || v !== exp_q[g]) begin errors++; $display("FAIL random_avg%0d: got %h ok=%0d want %h", g, v, ok, exp_q[g]); end
    end
    stop_sampling();
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] s[$];
    logic [DW-1:0] v;
    bit            ok;
    int            bad;
    int            base;
    int            n;
    for (int k = 0; k < NS; k++) begin
      v = 16'($urandom);
      s.push_back(v);
      push(0, v);
    end
    avg_ready = 1'b0;
    enable = 1'b1;
    get_avg(v, ok);
    checks++; if (!ok || v !== ref_mean(s)) begin errors++; $display("FAIL bp_avg: got %h ok=%0d want %h", v, ok, ref_mean(s)); end
    bad = 0;
    base = rd_rises;
    repeat (100) begin
      @(negedge clk);
      if (avg_valid !== 1'b1 || avg_data !== v || rd !== 1'b0) bad++;
    end
    checks++; if (bad != 0 || rd_rises != base) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles, %0d rd rises want 0", bad, rd_rises - base); end
    avg_ready = 1'b1;
    @(negedge clk);
    avg_ready = 1'b0;
    checks++; if (avg_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got avg_valid=%b want 0", avg_valid); end
    avg_ready = 1'b1;
    n = 0;
    while (rd_rises == base && n < 100) begin @(negedge clk); n++; end
    checks++; if (rd_rises == base) begin errors++; $display("FAIL bp_resume: got no rd within %0d cycles want one", n); end
    stop_sampling();
  endtask

  task automatic test_timeout();
    logic [DW-1:0] s[$];
    logic [DW-1:0] v;
    bit            ok;
    s = '{16'h0004, 16'h0004, 16'h0004, 16'h0004};
    push(0, 16'h4000 | 16'($urandom_range(0, 16'h3FFF)));
    push(1, '0);
    foreach (s[i]) push(0, s[i]);
    enable = 1'b1;
    get_avg(v, ok);
    checks++; if (!ok || v !== ref_mean(s)) begin errors++; $display("FAIL timeout_avg: got %h ok=%0d want %h", v, ok, ref_mean(s)); end
    checks++; if (last_silent_len != TO) begin errors++; $display("FAIL timeout_rd_len: got %0d want %0d", last_silent_len, TO); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %b want 1", timeout_err); end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: got %b want 0", timeout_err); end
    stop_sampling();
  endtask

  task automatic test_stale();
    logic [DW-1:0] s[$];
    logic [DW-1:0] v;
    bit            ok;
    int            done0;
    push(0, 16'($urandom));
    push(2, '0);
    for (int k = 0; k < NS; k++) begin
      v = 16'($urandom);
      s.push_back(v);
      push(0, v);
    end
    stale_rd_bad = 0;
    done0 = stale_done;
    enable = 1'b1;
    get_avg(v, ok);
    checks++; if (!ok || v !== ref_mean(s)) begin errors++; $display("FAIL stale_avg: got %h ok=%0d want %h", v, ok, ref_mean(s)); end
    checks++; if (stale_done != done0 + 1 || stale_rd_bad != 0) begin errors++; $display("FAIL stale_rd: got %0d rd-high cycles during stale d_ready want 0", stale_rd_bad); end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    stop_sampling();
  endtask

  task automatic test_control();
    logic [DW-1:0] s[$];
    logic [DW-1:0] v;
    bit            ok;
    int            base;
    int            sbase;
    int            bad;
    int            n;
    for (int k = 0; k < NS; k++) push(0, 16'($urandom));
    base = rd_rises;
    sbase = serves;
    enable = 1'b1;
    n = 0;
    while (rd_rises < base + 3 && n < 1000) begin @(negedge clk); n++; end
    enable = 1'b0;
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (avg_valid) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ctrl_no_avg: got %0d avg_valid cycles want 0", bad); end
    checks++; if (rd_rises != base + 3 || serves != sbase + 3) begin errors++; $display("FAIL ctrl_stop: got %0d rd / %0d served want 3 / 3", rd_rises - base, serves - sbase); end
    resp_q.delete();
    for (int k = 0; k < NS; k++) begin
      v = 16'($urandom);
      s.push_back(v);
      push(0, v);
    end
    enable = 1'b1;
    get_avg(v, ok);
    checks++; if (!ok || v !== ref_mean(s)) begin errors++; $display("FAIL ctrl_discard: got %h ok=%0d want %h", v, ok, ref_mean(s)); end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (rd !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL rst_mid_rd_seen: got rd=%b want 1", rd); end
    #2;
    rst_l = 1'b0;
    #1;
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL rst_mid_rd: got %b want 0", rd); end
    checks++; if (avg_valid !== 1'b0 || avg_data !== '0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got valid=%b data=%h err=%b want 0 0000 0", avg_valid, avg_data, timeout_err);
    end
    enable = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin : main
    test_reset();
    test_basic();
    test_full_scale();
    test_random();
    test_back_pressure();
    test_timeout();
    test_stale();
    test_control();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
